// File: rtl/tcu_uop_retire.sv
// Retire stage for TCU micro-ops: tracks per-warp uop completions and emits
// one commit per macro-instruction when its final uop retires.
module tcu_uop_retire #(
  parameter int NUM_UOPS    = 8,
  parameter int NUM_WARPS   = 4,
  parameter int UUID_WIDTH  = 44,
  parameter int NUM_THREADS = 4,
  localparam int CTR_W      = (NUM_UOPS > 1) ? $clog2(NUM_UOPS) : 1,
  localparam int NW_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NW_W-1:0]        in_wid,
  input  logic [CTR_W-1:0]       in_seq,
  input  logic [UUID_WIDTH-1:0]  in_uuid,
  input  logic [NUM_THREADS-1:0] in_tmask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NW_W-1:0]        out_wid,
  output logic [UUID_WIDTH-1:0]  out_uuid,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [NUM_WARPS-1:0]   warp_busy,
  output logic                   seq_err,
  output logic [NW_W-1:0]        seq_err_wid
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(NUM_UOPS - 1);

  logic [CTR_W-1:0]      cnt [NUM_WARPS];
  logic [CTR_W-1:0]      cnt_w;
  logic                  fire;
  logic                  final_beat;
  logic [UUID_WIDTH-1:0] uuid_clr;

  // Uniform backpressure for final and non-final beats keeps retire order intact.
  assign in_ready   = ~out_valid | out_ready;
  assign fire       = in_valid & in_ready;
  assign cnt_w      = cnt[in_wid];
  assign final_beat = (cnt_w == LAST);

  always_comb begin
    uuid_clr             = in_uuid;
    uuid_clr[31 -: CTR_W] = '0;
  end

  always_comb begin
    warp_busy = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      warp_busy[w] = (cnt[w] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        cnt[w] <= '0;
      end
    end else if (fire) begin
      cnt[in_wid] <= final_beat ? '0 : cnt_w + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_uuid  <= '0;
      out_tmask <= '0;
    end else if (fire && final_beat) begin
      out_valid <= 1'b1;
      out_wid   <= in_wid;
      out_uuid  <= uuid_clr;
      out_tmask <= in_tmask;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Only the first out-of-order beat is recorded; counting follows cnt, not in_seq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_err     <= 1'b0;
      seq_err_wid <= '0;
    end else if (fire && (in_seq != cnt_w) && !seq_err) begin
      seq_err     <= 1'b1;
      seq_err_wid <= in_wid;
    end
  end

endmodule

// File: tb/tb_tcu_uop_retire.sv
// Directed bench for tcu_uop_retire: table of per-cycle vectors plus
// hand-written sequences for async reset and the single-uop build.
module tb_tcu_uop_retire;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        in_valid, in_ready, out_valid, out_ready, seq_err;
  logic [1:0]  in_wid, out_wid, seq_err_wid;
  logic [2:0]  in_seq;
  logic [43:0] in_uuid, out_uuid;
  logic [3:0]  in_tmask, out_tmask, warp_busy;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_seq_err;
  logic [1:0]  b_in_wid, b_out_wid, b_seq_err_wid;
  logic [0:0]  b_in_seq;
  logic [43:0] b_in_uuid, b_out_uuid;
  logic [3:0]  b_in_tmask, b_out_tmask, b_warp_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  tcu_uop_retire #(.NUM_UOPS(8), .NUM_WARPS(4), .UUID_WIDTH(44), .NUM_THREADS(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_seq(in_seq),
    .in_uuid(in_uuid), .in_tmask(in_tmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
    .out_uuid(out_uuid), .out_tmask(out_tmask),
    .warp_busy(warp_busy), .seq_err(seq_err), .seq_err_wid(seq_err_wid)
  );

  tcu_uop_retire #(.NUM_UOPS(1), .NUM_WARPS(4), .UUID_WIDTH(44), .NUM_THREADS(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_wid(b_in_wid), .in_seq(b_in_seq),
    .in_uuid(b_in_uuid), .in_tmask(b_in_tmask),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_wid(b_out_wid),
    .out_uuid(b_out_uuid), .out_tmask(b_out_tmask),
    .warp_busy(b_warp_busy), .seq_err(b_seq_err), .seq_err_wid(b_seq_err_wid)
  );

  typedef struct {
    logic       vld;
    logic [1:0] wid;
    logic [2:0] seq;
    logic       ordy;
    logic       e_irdy;
    logic       e_ovld;
    logic [1:0] e_owid;
    logic [3:0] e_busy;
    logic       e_err;
    logic [1:0] e_ewid;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [43:0] mk_uuid(input logic [1:0] w, input logic [2:0] s);
    return {10'd0, w, s, 29'h0000_1234};
  endfunction

  function automatic logic [43:0] exp_uuid(input logic [1:0] w);
    return {10'd0, w, 3'b000, 29'h0000_1234};
  endfunction

  function automatic logic [3:0] mk_tmask(input logic [1:0] w);
    return 4'b0001 << w;
  endfunction

  function automatic void add(input logic vld, input logic [1:0] wid, input logic [2:0] seq,
                              input logic ordy, input logic e_irdy, input logic e_ovld,
                              input logic [1:0] e_owid, input logic [3:0] e_busy,
                              input logic e_err, input logic [1:0] e_ewid);
    vec_t v;
    v.vld = vld; v.wid = wid; v.seq = seq; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_owid = e_owid;
    v.e_busy = e_busy; v.e_err = e_err; v.e_ewid = e_ewid;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic vld, input logic [1:0] wid, input logic [2:0] seq, input logic ordy);
    in_valid  = vld;
    in_wid    = wid;
    in_seq    = seq;
    in_uuid   = mk_uuid(wid, seq);
    in_tmask  = mk_tmask(wid);
    out_ready = ordy;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.vld, v.wid, v.seq, v.ordy);
    #1;
    chk($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(v.e_irdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(v.e_ovld));
    chk($sformatf("v%0d warp_busy", idx), 64'(warp_busy), 64'(v.e_busy));
    chk($sformatf("v%0d seq_err", idx), 64'(seq_err), 64'(v.e_err));
    chk($sformatf("v%0d seq_err_wid", idx), 64'(seq_err_wid), 64'(v.e_ewid));
    if (v.e_ovld) begin
      chk($sformatf("v%0d out_wid", idx), 64'(out_wid), 64'(v.e_owid));
      chk($sformatf("v%0d out_uuid", idx), 64'(out_uuid), 64'(exp_uuid(v.e_owid)));
      chk($sformatf("v%0d out_tmask", idx), 64'(out_tmask), 64'(mk_tmask(v.e_owid)));
    end
  endtask

  task automatic step(input logic vld, input logic [1:0] wid, input logic [2:0] seq, input logic ordy);
    drive(vld, wid, seq, ordy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 2'd0, 3'd0, 1'b1);
    b_in_valid = 1'b0; b_in_wid = '0; b_in_seq = '0; b_in_uuid = '0; b_in_tmask = '0;
    b_out_ready = 1'b1;

    #3;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_uuid", 64'(out_uuid), 64'd0);
    chk("rst warp_busy", 64'(warp_busy), 64'd0);
    chk("rst seq_err", 64'(seq_err), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Warp 1 single instruction
    for (int s = 0; s < 7; s++) add(1, 1, 3'(s), 1, 1, 0, 0, 4'b0010, 0, 0);
    add(1, 1, 7, 1, 1, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
    // Warps 0 and 2 interleaved
    for (int s = 0; s < 7; s++) begin
      add(1, 0, 3'(s), 1, 1, 0, 0, (s == 0) ? 4'b0001 : 4'b0101, 0, 0);
      add(1, 2, 3'(s), 1, 1, 0, 0, 4'b0101, 0, 0);
    end
    add(1, 0, 7, 1, 1, 1, 0, 4'b0100, 0, 0);
    add(1, 2, 7, 1, 1, 1, 2, 4'b0000, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
    // Backpressure: pending commit blocks final and non-final beats
    for (int s = 0; s < 7; s++) add(1, 0, 3'(s), 1, 1, 0, 0, 4'b0001, 0, 0);
    for (int s = 0; s < 7; s++) add(1, 1, 3'(s), 1, 1, 0, 0, 4'b0011, 0, 0);
    add(1, 0, 7, 1, 1, 1, 0, 4'b0010, 0, 0);
    add(1, 1, 7, 0, 0, 1, 0, 4'b0010, 0, 0);
    add(1, 2, 0, 0, 0, 1, 0, 4'b0010, 0, 0);
    add(1, 1, 7, 1, 1, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0);
    // Sequence error on warp 3, counting continues from cnt
    add(1, 3, 0, 1, 1, 0, 0, 4'b1000, 0, 0);
    add(1, 3, 1, 1, 1, 0, 0, 4'b1000, 0, 0);
    add(1, 3, 3, 1, 1, 0, 0, 4'b1000, 1, 3);
    add(1, 3, 5, 1, 1, 0, 0, 4'b1000, 1, 3);
    add(1, 3, 4, 1, 1, 0, 0, 4'b1000, 1, 3);
    add(1, 3, 5, 1, 1, 0, 0, 4'b1000, 1, 3);
    add(1, 3, 6, 1, 1, 0, 0, 4'b1000, 1, 3);
    add(1, 3, 7, 1, 1, 1, 3, 4'b0000, 1, 3);
    add(0, 0, 0, 1, 1, 0, 0, 4'b0000, 1, 3);
    add(1, 0, 5, 1, 1, 0, 0, 4'b0001, 1, 3);

    foreach (vecs[i]) apply(vecs[i], i);

    // Async reset with a commit pending and warps mid-instruction
    for (int s = 0; s < 8; s++) step(1, 2, 3'(s), 1);
    step(1, 0, 1, 0);
    chk("pre-rst out_valid", 64'(out_valid), 64'd1);
    chk("pre-rst warp_busy", 64'(warp_busy), 64'b0001);
    #2;
    reset = 1'b1;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst out_wid", 64'(out_wid), 64'd0);
    chk("arst out_uuid", 64'(out_uuid), 64'd0);
    chk("arst out_tmask", 64'(out_tmask), 64'd0);
    chk("arst warp_busy", 64'(warp_busy), 64'd0);
    chk("arst seq_err", 64'(seq_err), 64'd0);
    chk("arst seq_err_wid", 64'(seq_err_wid), 64'd0);
    drive(1'b0, 2'd0, 3'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 7; s++) begin
      step(1, 0, 3'(s), 1);
      chk($sformatf("post-rst busy s%0d", s), 64'(warp_busy), 64'b0001);
      chk($sformatf("post-rst ovld s%0d", s), 64'(out_valid), 64'd0);
    end
    step(1, 0, 7, 1);
    chk("post-rst commit valid", 64'(out_valid), 64'd1);
    chk("post-rst commit wid", 64'(out_wid), 64'd0);
    chk("post-rst commit uuid", 64'(out_uuid), 64'(exp_uuid(2'd0)));
    chk("post-rst seq_err", 64'(seq_err), 64'd0);
    step(0, 0, 0, 1);
    chk("post-rst drained", 64'(out_valid), 64'd0);

    // Single-uop build: every beat commits
    for (int w = 0; w < 3; w++) begin
      b_in_valid = 1'b1;
      b_in_wid   = 2'(w);
      b_in_seq   = 1'b0;
      b_in_uuid  = {10'd0, 2'(w), 1'b1, 31'h0000_1234};
      b_in_tmask = 4'b0001 << w;
      #1;
      chk($sformatf("u1 in_ready w%0d", w), 64'(b_in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("u1 out_valid w%0d", w), 64'(b_out_valid), 64'd1);
      chk($sformatf("u1 out_wid w%0d", w), 64'(b_out_wid), 64'(w));
      chk($sformatf("u1 out_uuid w%0d", w), 64'(b_out_uuid), 64'({10'd0, 2'(w), 1'b0, 31'h0000_1234}));
      chk($sformatf("u1 out_tmask w%0d", w), 64'(b_out_tmask), 64'(4'b0001 << w));
      chk($sformatf("u1 warp_busy w%0d", w), 64'(b_warp_busy), 64'd0);
    end
    b_in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("u1 drained", 64'(b_out_valid), 64'd0);
    chk("u1 seq_err", 64'(b_seq_err), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
